// File: rtl/vga_comp_pkg.sv
// vga_comp_pkg: shared modes, colour constants and rainbow colour mapping for the VGA compositor
package vga_comp_pkg;
    typedef logic [11:0] rgb12;
    typedef enum logic [1:0] {
        MODE_SOLID    = 2'b00,
        MODE_RAINBOW  = 2'b01,
        MODE_BLINK    = 2'b10,
        MODE_DISABLED = 2'b11
    } mode_e;
    localparam rgb12 AXIS_RGB = 12'hF00;
    localparam rgb12 TICK_RGB = 12'h09F;
    localparam rgb12 GRID_RGB = 12'h0F0;
    localparam rgb12 BG_RGB   = 12'h000;
    function automatic rgb12 rainbow_rgb(input logic [6:0] step);
        logic [3:0] f;
        f = step[3:0];
        case (step[6:4])
            3'd0:    rainbow_rgb = {4'hF, f, 4'h0};
            3'd1:    rainbow_rgb = {~f, 4'hF, 4'h0};
            3'd2:    rainbow_rgb = {4'h0, 4'hF, f};
            3'd3:    rainbow_rgb = {4'h0, ~f, 4'hF};
            3'd4:    rainbow_rgb = {f, 4'h0, 4'hF};
            3'd5:    rainbow_rgb = {4'hF, 4'h0, ~f};
            default: rainbow_rgb = AXIS_RGB;
        endcase
    endfunction
endpackage

// File: rtl/vga_rainbow_seq.sv
// vga_rainbow_seq: 96-step rainbow colour sequencer advanced once per frame
module vga_rainbow_seq
    import vga_comp_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_frame_start,
    output rgb12 o_rgb
);
    logic [6:0] r_step;
    logic [6:0] w_next;
    rgb12       r_rgb;
    assign w_next = (r_step == 7'd95) ? 7'd0 : r_step + 7'd1;
    assign o_rgb  = r_rgb;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_step <= 7'd0;
            r_rgb  <= rainbow_rgb(7'd0);
        end else if (i_frame_start) begin
            r_step <= w_next;
            r_rgb  <= rainbow_rgb(w_next);
        end
    end
endmodule

// File: rtl/vga_layer_compositor.sv
// vga_layer_compositor: two-stage priority compositor of overlay layers over an axis/tick/grid background
module vga_layer_compositor
    import vga_comp_pkg::*;
#(
    parameter int NUM_LAYERS   = 8,
    parameter int COORD_W      = 12,
    parameter int AXIS_X       = 640,
    parameter int AXIS_Y       = 512,
    parameter int GRID_X       = 80,
    parameter int GRID_Y       = 64,
    parameter int TICK_X       = 20,
    parameter int TICK_Y       = 16,
    parameter int TICK_HALF    = 10,
    parameter int BLINK_FRAMES = 16,
    localparam int AW          = $clog2(NUM_LAYERS + 1)
) (
    input  logic                  i_clk_vga,
    input  logic                  i_reset_n,
    input  logic [COORD_W-1:0]    i_vga_horz_coord,
    input  logic [COORD_W-1:0]    i_vga_vert_coord,
    input  logic                  i_pix_valid,
    input  logic                  i_frame_start,
    input  logic [NUM_LAYERS-1:0] i_layer_req,
    input  logic                  i_cfg_we,
    input  logic [AW-1:0]         i_cfg_addr,
    input  logic [13:0]           i_cfg_data,
    output logic [3:0]            o_vga_red,
    output logic [3:0]            o_vga_green,
    output logic [3:0]            o_vga_blue,
    output logic                  o_pix_valid_out
);
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [COORD_W:0]   ext_t;
    mode_e                 r_mode [NUM_LAYERS];
    rgb12                  r_rgb  [NUM_LAYERS];
    logic [2:0]            r_bg_en;
    logic [BW-1:0]         r_blink_cnt;
    logic                  r_blink_on;
    logic                  r_s1_valid;
    logic                  r_s1_axis;
    logic                  r_s1_tick;
    logic                  r_s1_grid;
    logic [NUM_LAYERS-1:0] r_s1_req;
    rgb12                  r_s1_rgb [NUM_LAYERS];
    rgb12                  r_out;
    logic                  r_valid_out;
    rgb12                  w_rainbow;
    ext_t                  w_dx;
    ext_t                  w_dy;
    ext_t                  w_adx;
    ext_t                  w_ady;
    logic                  w_axis;
    logic                  w_tick;
    logic                  w_grid;
    logic [NUM_LAYERS-1:0] w_req;
    rgb12                  w_pix;

    vga_rainbow_seq u_rainbow (
        .i_clk         (i_clk_vga),
        .i_rst_n       (i_reset_n),
        .i_frame_start (i_frame_start),
        .o_rgb         (w_rainbow)
    );

    always_ff @(posedge i_clk_vga) begin
        if (!i_reset_n) begin
            r_bg_en <= 3'b000;
            for (int l = 0; l < NUM_LAYERS; l++) begin
                r_mode[l] <= MODE_DISABLED;
                r_rgb[l]  <= BG_RGB;
            end
        end else if (i_cfg_we) begin
            if (i_cfg_addr == AW'(NUM_LAYERS))
                r_bg_en <= i_cfg_data[2:0];
            for (int l = 0; l < NUM_LAYERS; l++) begin
                if (i_cfg_addr == AW'(l)) begin
                    r_mode[l] <= mode_e'(i_cfg_data[13:12]);
                    r_rgb[l]  <= i_cfg_data[11:0];
                end
            end
        end
    end

    always_ff @(posedge i_clk_vga) begin
        if (!i_reset_n) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (i_frame_start) begin
            r_blink_cnt <= (r_blink_cnt == BW'(BLINK_FRAMES - 1)) ? '0 : r_blink_cnt + 1'b1;
            r_blink_on  <= (r_blink_cnt == BW'(BLINK_FRAMES - 1)) ? ~r_blink_on : r_blink_on;
        end
    end

    // Distances use one extra bit so coordinates left of / above the axis do not wrap.
    assign w_dx   = {1'b0, i_vga_horz_coord} - ext_t'(AXIS_X);
    assign w_dy   = {1'b0, i_vga_vert_coord} - ext_t'(AXIS_Y);
    assign w_adx  = w_dx[COORD_W] ? -w_dx : w_dx;
    assign w_ady  = w_dy[COORD_W] ? -w_dy : w_dy;
    assign w_axis = (i_vga_horz_coord == coord_t'(AXIS_X)) || (i_vga_vert_coord == coord_t'(AXIS_Y));
    assign w_tick = ((i_vga_horz_coord % coord_t'(TICK_X)) == '0 && w_ady < ext_t'(TICK_HALF)) ||
                    ((i_vga_vert_coord % coord_t'(TICK_Y)) == '0 && w_adx < ext_t'(TICK_HALF));
    assign w_grid = ((i_vga_horz_coord % coord_t'(GRID_X)) == '0) ||
                    ((i_vga_vert_coord % coord_t'(GRID_Y)) == '0);

    always_comb begin
        w_req = '0;
        for (int l = 0; l < NUM_LAYERS; l++)
            w_req[l] = i_layer_req[l] && r_mode[l] != MODE_DISABLED && (r_mode[l] != MODE_BLINK || r_blink_on);
    end

    always_ff @(posedge i_clk_vga) begin
        if (!i_reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_axis  <= 1'b0;
            r_s1_tick  <= 1'b0;
            r_s1_grid  <= 1'b0;
            r_s1_req   <= '0;
            for (int l = 0; l < NUM_LAYERS; l++)
                r_s1_rgb[l] <= BG_RGB;
        end else begin
            r_s1_valid <= i_pix_valid;
            r_s1_axis  <= w_axis && r_bg_en[0];
            r_s1_tick  <= w_tick && r_bg_en[1];
            r_s1_grid  <= w_grid && r_bg_en[2];
            r_s1_req   <= w_req;
            for (int l = 0; l < NUM_LAYERS; l++)
                r_s1_rgb[l] <= (r_mode[l] == MODE_RAINBOW) ? w_rainbow : r_rgb[l];
        end
    end

    always_comb begin
        w_pix = r_s1_axis ? AXIS_RGB : r_s1_tick ? TICK_RGB : r_s1_grid ? GRID_RGB : BG_RGB;
        for (int l = NUM_LAYERS - 1; l >= 0; l--)
            w_pix = r_s1_req[l] ? r_s1_rgb[l] : w_pix;
    end

    always_ff @(posedge i_clk_vga) begin
        if (!i_reset_n) begin
            r_out       <= BG_RGB;
            r_valid_out <= 1'b0;
        end else begin
            r_out       <= r_s1_valid ? w_pix : BG_RGB;
            r_valid_out <= r_s1_valid;
        end
    end

    assign o_vga_red       = r_out[11:8];
    assign o_vga_green     = r_out[7:4];
    assign o_vga_blue      = r_out[3:0];
    assign o_pix_valid_out = r_valid_out;
endmodule

// File: tb/tb_vga_layer_compositor.sv
// tb_vga_layer_compositor: directed and reference-model checks of the VGA layer compositor
module tb_vga_layer_compositor;
    logic        clk = 1'b0;
    logic        i_reset_n;
    logic [11:0] i_x;
    logic [11:0] i_y;
    logic        i_pix_valid;
    logic        i_frame_start;
    logic [7:0]  i_layer_req;
    logic        i_cfg_we;
    logic [3:0]  i_cfg_addr;
    logic [13:0] i_cfg_data;
    logic [3:0]  o_red;
    logic [3:0]  o_green;
    logic [3:0]  o_blue;
    logic        o_valid;
    logic [12:0] w_out;
    int          errors = 0;
    int          checks = 0;
    int          fs_count = 0;
    logic [1:0]  m_mode [8];
    logic [11:0] m_rgb  [8];
    logic [2:0]  m_bg;
    logic        m_blink_on;
    logic [11:0] m_rainbow;

    always #5 clk = ~clk;
    assign w_out = {o_valid, o_red, o_green, o_blue};

    vga_layer_compositor #(.BLINK_FRAMES(2)) dut (
        .i_clk_vga        (clk),
        .i_reset_n        (i_reset_n),
        .i_vga_horz_coord (i_x),
        .i_vga_vert_coord (i_y),
        .i_pix_valid      (i_pix_valid),
        .i_frame_start    (i_frame_start),
        .i_layer_req      (i_layer_req),
        .i_cfg_we         (i_cfg_we),
        .i_cfg_addr       (i_cfg_addr),
        .i_cfg_data       (i_cfg_data),
        .o_vga_red        (o_red),
        .o_vga_green      (o_green),
        .o_vga_blue       (o_blue),
        .o_pix_valid_out  (o_valid)
    );

    task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int l = 0; l < 8; l++) begin
            m_mode[l] = 2'b11;
            m_rgb[l]  = 12'h000;
        end
        m_bg       = 3'b000;
        m_blink_on = 1'b1;
        m_rainbow  = 12'hF00;
        fs_count   = 0;
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0;
        step();
        i_reset_n = 1'b1;
        model_reset();
    endtask

    task automatic cfg(input logic [3:0] a, input logic [13:0] d);
        i_cfg_we   = 1'b1;
        i_cfg_addr = a;
        i_cfg_data = d;
        step();
        i_cfg_we = 1'b0;
        if (a < 4'd8) begin
            m_mode[a[2:0]] = d[13:12];
            m_rgb[a[2:0]]  = d[11:0];
        end else if (a == 4'd8) begin
            m_bg = d[2:0];
        end
    endtask

    task automatic pix(input int x, input int y, input logic [7:0] req, input logic v);
        i_x         = 12'(x);
        i_y         = 12'(y);
        i_layer_req = req;
        i_pix_valid = v;
    endtask

    task automatic expect_pix(input string tag, input int x, input int y, input logic [7:0] req, input logic [11:0] exp);
        pix(x, y, req, 1'b1);
        step();
        i_pix_valid = 1'b0;
        step();
        check(tag, w_out, {1'b1, exp});
    endtask

    task automatic frame();
        i_frame_start = 1'b1;
        step();
        i_frame_start = 1'b0;
        fs_count++;
    endtask

    function automatic logic [12:0] ref_pix(input int x, input int y, input logic [7:0] req, input logic v);
        int dx;
        int dy;
        if (!v) return 13'h0000;
        for (int l = 0; l < 8; l++)
            if (req[l] && m_mode[l] != 2'b11 && (m_mode[l] != 2'b10 || m_blink_on))
                return {1'b1, (m_mode[l] == 2'b01) ? m_rainbow : m_rgb[l]};
        dx = (x > 640) ? x - 640 : 640 - x;
        dy = (y > 512) ? y - 512 : 512 - y;
        if (m_bg[0] && (x == 640 || y == 512)) return {1'b1, 12'hF00};
        if (m_bg[1] && ((x % 20 == 0 && dy < 10) || (y % 16 == 0 && dx < 10))) return {1'b1, 12'h09F};
        if (m_bg[2] && (x % 80 == 0 || y % 64 == 0)) return {1'b1, 12'h0F0};
        return {1'b1, 12'h000};
    endfunction

    initial begin
        int          rb_n   [9] = '{0, 16, 20, 32, 50, 70, 88, 96, 97};
        logic [11:0] rb_exp [9] = '{12'hF00, 12'hFF0, 12'hBF0, 12'h0F0, 12'h0DF, 12'h60F, 12'hF07, 12'hF00, 12'hF10};
        logic [12:0] prev;
        logic [12:0] e;
        int          x;
        int          y;
        logic [7:0]  req;
        logic        v;
        i_reset_n     = 1'b0;
        i_frame_start = 1'b0;
        i_cfg_we      = 1'b1;
        i_cfg_addr    = 4'd8;
        i_cfg_data    = 14'h0007;
        pix(640, 512, 8'hFF, 1'b1);
        model_reset();
        step();
        check("reset_a", w_out, 13'h0000);
        step();
        check("reset_b", w_out, 13'h0000);
        i_reset_n = 1'b1;
        i_cfg_we  = 1'b0;
        #1;
        check("release_a", w_out, 13'h0000);
        step();
        check("release_b", w_out, 13'h0000);
        step();
        check("reset_cfg_cleared", w_out, 13'h1000);

        cfg(4'd2, 14'h00AB);
        cfg(4'd5, 14'h0123);
        expect_pix("prio_l2_over_l5", 161, 101, 8'h24, 12'h0AB);
        cfg(4'd2, 14'h30AB);
        expect_pix("l2_disabled", 161, 101, 8'h24, 12'h123);

        cfg(4'd8, 14'h0007);
        expect_pix("axis_x", 640, 100, 8'h00, 12'hF00);
        expect_pix("axis_y", 660, 512, 8'h00, 12'hF00);
        expect_pix("tick", 660, 505, 8'h00, 12'h09F);
        expect_pix("grid", 160, 100, 8'h00, 12'h0F0);
        expect_pix("plain", 161, 101, 8'h00, 12'h000);
        expect_pix("grid_origin", 0, 0, 8'h00, 12'h0F0);
        expect_pix("tick_edge_out", 630, 16, 8'h00, 12'h000);
        expect_pix("tick_edge_in", 631, 16, 8'h00, 12'h09F);
        expect_pix("layer_over_axis", 640, 100, 8'h20, 12'h123);
        expect_pix("disabled_transparent", 640, 100, 8'h04, 12'hF00);
        cfg(4'd8, 14'h0005);
        expect_pix("tick_off", 660, 505, 8'h00, 12'h000);
        cfg(4'd8, 14'h0007);

        pix(161, 101, 8'h20, 1'b0);
        step();
        step();
        check("invalid_black", w_out, 13'h0000);

        cfg(4'd1, 14'h1000);
        cfg(4'd3, 14'h20C0);
        cfg(4'd7, 14'h0777);
        prev = '0;
        for (int i = 0; i < 40; i++) begin
            x   = ($urandom_range(0, 1) == 1) ? 600 + $urandom_range(0, 80) : $urandom_range(0, 4095);
            y   = ($urandom_range(0, 1) == 1) ? 480 + $urandom_range(0, 64) : $urandom_range(0, 4095);
            req = 8'($urandom & $urandom & $urandom);
            v   = ($urandom_range(0, 7) != 0);
            pix(x, y, req, v);
            e = ref_pix(x, y, req, v);
            step();
            if (i > 0) check("random", w_out, prev);
            prev = e;
        end
        i_pix_valid = 1'b0;
        step();
        check("random_last", w_out, prev);

        cfg(4'd0, 14'h2FFF);
        for (int f = 0; f < 8; f++) begin
            expect_pix("blink", 161, 101, 8'h21, ((f / 2) % 2 == 0) ? 12'hFFF : 12'h123);
            frame();
        end

        pix(161, 101, 8'h01, 1'b1);
        step();
        cfg(4'd0, 14'h00AB);
        check("cfg_stream_p0", w_out, 13'h1FFF);
        step();
        check("cfg_stream_p1", w_out, 13'h1FFF);
        step();
        check("cfg_stream_p2", w_out, 13'h10AB);

        cfg(4'd9, 14'h0000);
        cfg(4'd15, 14'h0000);
        expect_pix("bad_addr_bg", 640, 100, 8'h00, 12'hF00);
        expect_pix("bad_addr_l1_rainbow", 161, 101, 8'h02, 12'hF80);

        do_reset();
        cfg(4'd0, 14'h1000);
        for (int k = 0; k < 9; k++) begin
            while (fs_count < rb_n[k]) frame();
            expect_pix($sformatf("rainbow_%0d", rb_n[k]), 161, 101, 8'h01, rb_exp[k]);
        end
        pix(161, 101, 8'h01, 1'b1);
        i_frame_start = 1'b1;
        step();
        i_frame_start = 1'b0;
        step();
        check("fs_coincident_old", w_out, 13'h1F10);
        step();
        check("fs_coincident_new", w_out, 13'h1F20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
